// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: ALU memory opcodes, LSU state encoding and store-lane helpers
// shared by the load/store unit and its load-extension datapath.
package load_store_unit_pkg;

    localparam int unsigned ALUCODE_W = 6;
    localparam int unsigned DATA_W    = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // ALU codes; only the eight memory codes are acted on by the LSU
    localparam logic [ALUCODE_W-1:0] ALU_ADD = 6'd0;
    localparam logic [ALUCODE_W-1:0] ALU_LB  = 6'd20;
    localparam logic [ALUCODE_W-1:0] ALU_LH  = 6'd21;
    localparam logic [ALUCODE_W-1:0] ALU_LW  = 6'd22;
    localparam logic [ALUCODE_W-1:0] ALU_LBU = 6'd23;
    localparam logic [ALUCODE_W-1:0] ALU_LHU = 6'd24;
    localparam logic [ALUCODE_W-1:0] ALU_SB  = 6'd25;
    localparam logic [ALUCODE_W-1:0] ALU_SH  = 6'd26;
    localparam logic [ALUCODE_W-1:0] ALU_SW  = 6'd27;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic is_load_op(input logic [ALUCODE_W-1:0] code);
        return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
               (code == ALU_LBU) || (code == ALU_LHU);
    endfunction

    function automatic logic is_store_op(input logic [ALUCODE_W-1:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0
    function automatic logic is_misaligned(input logic [ALUCODE_W-1:0] code,
                                           input logic [1:0]           lane);
        logic mis;
        mis = DISABLE;
        if ((code == ALU_LH) || (code == ALU_LHU) || (code == ALU_SH)) begin
            mis = lane[0];
        end else if ((code == ALU_LW) || (code == ALU_SW)) begin
            mis = (lane != 2'b00);
        end
        return mis;
    endfunction

    function automatic logic [3:0] store_strb(input logic [ALUCODE_W-1:0] code,
                                              input logic [1:0]           lane);
        logic [3:0] strb;
        strb = 4'b0000;
        if (code == ALU_SB) begin
            strb = 4'b0001 << lane;
        end else if (code == ALU_SH) begin
            strb = 4'b0011 << lane;
        end else if (code == ALU_SW) begin
            strb = 4'b1111;
        end
        return strb;
    endfunction

    // Replicate the store operand so every strobed lane sees the right bytes
    function automatic logic [DATA_W-1:0] store_lanes(input logic [ALUCODE_W-1:0] code,
                                                      input logic [DATA_W-1:0]    data);
        logic [DATA_W-1:0] wd;
        wd = '0;
        if (code == ALU_SB) begin
            wd = {4{data[7:0]}};
        end else if (code == ALU_SH) begin
            wd = {2{data[15:0]}};
        end else if (code == ALU_SW) begin
            wd = data;
        end
        return wd;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// load_extend: combinational load-data extraction.
// Ports: alucode (load opcode), lane (addr[1:0]), mem_rdata (read word)
//        -> load_data_c (byte/halfword selected, sign/zero extended; 0 for non-loads).
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [ALUCODE_W-1:0] alucode,
    input  logic [1:0]           lane,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    load_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lane)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Extension by opcode
    always_comb begin
        load_data_c = '0;
        if (alucode == ALU_LB) begin
            load_data_c = {{24{byte_sel[7]}}, byte_sel};
        end else if (alucode == ALU_LBU) begin
            load_data_c = {24'd0, byte_sel};
        end else if (alucode == ALU_LH) begin
            load_data_c = {{16{half_sel[15]}}, half_sel};
        end else if (alucode == ALU_LHU) begin
            load_data_c = {16'd0, half_sel};
        end else if (alucode == ALU_LW) begin
            load_data_c = mem_rdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequential LSU between the ALU and a word-wide data-memory port.
// Core side: req_valid/alucode/addr/store_data in; busy, done, misaligned, load_data out.
// Memory side: mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata out; mem_ready/mem_rdata in.
// One transaction at a time: IDLE -> ACCESS (wait for mem_ready) -> RESP (done pulse) -> IDLE,
// or IDLE -> RESP directly for rejected misaligned accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [5:0]           alucode,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          store_data,
    output logic                 busy,
    output logic                 done,
    output logic                 misaligned,
    output logic [31:0]          load_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata
);

    lsu_state_e         state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [1:0]         lane_q, lane_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mis_q, mis_d;
    logic [31:0]        load_data_q, load_data_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        ext_data_c;

    // Extraction from the latched opcode/lane so the read path is independent of core inputs
    load_extend u_load_extend (
        .alucode     (op_q),
        .lane        (lane_q),
        .mem_rdata   (mem_rdata),
        .load_data_c (ext_data_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        mis_d       = DISABLE;
        load_data_d = load_data_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid && (is_load_op(alucode) || is_store_op(alucode))) begin
                    load_data_d = '0;
                    if (is_misaligned(alucode, addr[1:0])) begin
                        state_d = LSU_RESP;
                        mis_d   = ENABLE;
                    end else begin
                        state_d     = LSU_ACCESS;
                        op_d        = alucode;
                        lane_d      = addr[1:0];
                        mem_we_d    = is_store_op(alucode);
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb_d = store_strb(alucode, addr[1:0]);
                        mem_wdata_d = store_lanes(alucode, store_data);
                    end
                end
            end
            LSU_ACCESS: begin
                if (mem_ready) begin
                    state_d = LSU_RESP;
                    if (is_load_op(op_q)) begin
                        load_data_d = ext_data_c;
                    end
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they line up with it
        busy_d    = (state_d != LSU_IDLE);
        mem_req_d = (state_d == LSU_ACCESS);
        done_d    = (state_d == LSU_RESP);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            op_q        <= '0;
            lane_q      <= '0;
            busy_q      <= DISABLE;
            done_q      <= DISABLE;
            mis_q       <= DISABLE;
            load_data_q <= '0;
            mem_req_q   <= DISABLE;
            mem_we_q    <= DISABLE;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign load_data  = load_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed, table-driven bench for load_store_unit with
// hand-written sequences for wait states, ignored requests and mid-access reset.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_chk;
    int n_pass;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .alucode    (alucode),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  code;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        mis;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic [31:0] ldata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input logic mis, input logic we,
                       input logic [3:0] strb, input logic [31:0] wd,
                       input logic [31:0] ma, input logic [31:0] ld);
        vec_t v;
        v.code = code; v.addr = a; v.sdata = sd; v.rdata = rd; v.mis = mis; v.we = we;
        v.strb = strb; v.wdata = wd; v.maddr = ma; v.ldata = ld;
        vecs.push_back(v);
    endtask

    // One access with mem_ready held high; checks each cycle after the accepting edge
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        req_valid = 1'b1; alucode = v.code; addr = v.addr; store_data = v.sdata;
        mem_ready = 1'b1; mem_rdata = v.rdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.mis) begin
            chk($sformatf("v%0d_c1_done", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d_c1_misaligned", idx), 32'(misaligned), 32'd1);
            chk($sformatf("v%0d_c1_mem_req", idx), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_c1_load_data", idx), load_data, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_c2_done", idx), 32'(done), 32'd0);
            chk($sformatf("v%0d_c2_mem_req", idx), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_c2_busy", idx), 32'(busy), 32'd0);
        end else begin
            chk($sformatf("v%0d_c1_mem_req", idx), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d_c1_busy", idx), 32'(busy), 32'd1);
            chk($sformatf("v%0d_c1_done", idx), 32'(done), 32'd0);
            chk($sformatf("v%0d_c1_mem_we", idx), 32'(mem_we), 32'(v.we));
            chk($sformatf("v%0d_c1_mem_addr", idx), mem_addr, v.maddr);
            chk($sformatf("v%0d_c1_mem_wstrb", idx), 32'(mem_wstrb), 32'(v.strb));
            if (v.we) begin
                chk($sformatf("v%0d_c1_mem_wdata", idx), mem_wdata, v.wdata);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_c2_done", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d_c2_misaligned", idx), 32'(misaligned), 32'd0);
            chk($sformatf("v%0d_c2_mem_req", idx), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_c2_load_data", idx), load_data, v.ldata);
            @(posedge clk); #1;
            chk($sformatf("v%0d_c3_done", idx), 32'(done), 32'd0);
            chk($sformatf("v%0d_c3_busy", idx), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; req_valid = 1'b0; alucode = '0; addr = '0; store_data = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        //          code     addr         sdata         rdata         mis  we   strb     wdata         maddr         ldata
        add(ALU_SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h100, 32'h0);
        add(ALU_SB,  32'h103, 32'h123456AB, 32'h0,        1'b0, 1'b1, 4'b1000, 32'hABABABAB, 32'h100, 32'h0);
        add(ALU_SB,  32'h101, 32'h00000077, 32'h0,        1'b0, 1'b1, 4'b0010, 32'h77777777, 32'h100, 32'h0);
        add(ALU_SH,  32'h102, 32'h1234ABCD, 32'h0,        1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100, 32'h0);
        add(ALU_LB,  32'h101, 32'h0,        32'h1234F678, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'hFFFFFFF6);
        add(ALU_LBU, 32'h101, 32'h0,        32'h1234F678, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'h000000F6);
        add(ALU_LH,  32'h102, 32'h0,        32'h8001F678, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'hFFFF8001);
        add(ALU_LHU, 32'h102, 32'h0,        32'h8001F678, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'h00008001);
        add(ALU_LH,  32'h100, 32'h0,        32'h8001F678, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'hFFFFF678);
        add(ALU_LB,  32'h100, 32'h0,        32'h0000007F, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'h0000007F);
        add(ALU_LB,  32'h103, 32'h0,        32'h80000000, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'hFFFFFF80);
        add(ALU_LBU, 32'h103, 32'h0,        32'h80000000, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h100, 32'h00000080);
        add(ALU_LW,  32'h104, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h104, 32'hCAFEF00D);
        add(ALU_LW,  32'h102, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,   32'h0);
        add(ALU_LH,  32'h101, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,   32'h0);
        add(ALU_SH,  32'h103, 32'h1234,     32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,   32'h0);
        add(ALU_SW,  32'h101, 32'h1234,     32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,   32'h0);

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Non-memory opcode is ignored
        @(negedge clk);
        req_valid = 1'b1; alucode = ALU_ADD; addr = 32'h100; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("nonmem_busy", 32'(busy), 32'd0);
        chk("nonmem_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        chk("nonmem_done", 32'(done), 32'd0);
        req_valid = 1'b0;

        // LW with three wait cycles and a stray request during the wait
        @(negedge clk);
        req_valid = 1'b1; alucode = ALU_LW; addr = 32'h200; mem_ready = 1'b0; mem_rdata = 32'h11223344;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("wait_c%0d_mem_req", k), 32'(mem_req), 32'd1);
            chk($sformatf("wait_c%0d_mem_addr", k), mem_addr, 32'h200);
            chk($sformatf("wait_c%0d_mem_we", k), 32'(mem_we), 32'd0);
            chk($sformatf("wait_c%0d_done", k), 32'(done), 32'd0);
            @(negedge clk);
            mem_ready = (k == 4);
            req_valid = (k == 2);
            alucode   = (k == 2) ? ALU_SW : ALU_LW;
            addr      = (k == 2) ? 32'h300 : 32'h200;
        end
        @(posedge clk); #1;
        chk("wait_done", 32'(done), 32'd1);
        chk("wait_load_data", load_data, 32'h11223344);
        chk("wait_mem_req_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("wait_after_done", 32'(done), 32'd0);
        chk("wait_after_busy", 32'(busy), 32'd0);
        chk("wait_stray_ignored", 32'(mem_req), 32'd0);

        // Asynchronous reset in ACCESS
        @(negedge clk);
        req_valid = 1'b1; alucode = ALU_SW; addr = 32'h40; store_data = 32'h5; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("arst_pre_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t v;
            v.code = ALU_LW; v.addr = 32'h0; v.sdata = 32'h0; v.rdata = 32'h55AA55AA;
            v.mis = 1'b0; v.we = 1'b0; v.strb = 4'b0000; v.wdata = 32'h0;
            v.maddr = 32'h0; v.ldata = 32'h55AA55AA;
            run_vec(v, 99);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
